// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_pkg
// Brief    : Shared types and helpers for the data-memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package data_mem_pkg;

    localparam int WORD_BYTES = 4;
    localparam int BE_W       = 4;
    localparam int ADDR_MAX   = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Full word number of a byte address; callers slice off the index bits.
    function automatic logic [ADDR_MAX-3:0] word_index(input logic [ADDR_MAX-1:0] addr);
        return addr[ADDR_MAX-1:2];
    endfunction

endpackage : data_mem_pkg
`default_nettype wire

// File: rtl/mem_word_ram.sv
`default_nettype none
// ============================================================================
// Module   : mem_word_ram
// Brief    : DEPTH_WORDS x 32 synchronous RAM, 4-lane byte write, registered read.
// Revision : 1.0 - initial release
// ============================================================================
module mem_word_ram
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [BE_W-1:0]   i_be,
    input  logic [IDX_W-1:0]  i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (i_we && i_be[i]) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule : mem_word_ram
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : Load/store port responder with wait-state latency and byte-lane
//            writes. Define MEM_ADDR_CHECK_EN to flag out-of-range addresses.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [3:0]        req_be,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    import data_mem_pkg::*;

    localparam int c_idx_w = $clog2(DEPTH_WORDS);
    localparam int c_cnt_w = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_load =
        (WAIT_CYCLES > 0) ? c_cnt_w'(WAIT_CYCLES - 1) : '0;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_we;
    logic [c_idx_w-1:0]   r_idx;
    logic [DATA_W-1:0]    r_wdata;
    logic [BE_W-1:0]      r_be;
    logic                 r_oor;

    logic                 w_accept;
    logic                 w_rsp;
    logic [ADDR_MAX-3:0]  w_word_cur;
    logic [c_idx_w-1:0]   w_idx_cur;
    logic                 w_oor_cur;
    logic [c_idx_w-1:0]   w_ram_addr;
    logic                 w_ram_we;
    logic [31:0]          w_ram_rdata;

    assign w_word_cur = word_index(ADDR_MAX'(req_addr));
    assign w_idx_cur  = w_word_cur[c_idx_w-1:0];

`ifdef MEM_ADDR_CHECK_EN
    assign w_oor_cur = |w_word_cur[ADDR_MAX-3:c_idx_w];
`else
    logic w_unused_hi;
    assign w_unused_hi = ^w_word_cur[ADDR_MAX-3:c_idx_w];
    assign w_oor_cur   = 1'b0;
`endif

    // Reset gates the handshake and response combinationally so that a
    // reset cycle never shows ready, a response, or a committed store.
    assign req_ready = (r_state == IDLE) && !Reset;
    assign w_accept  = req_valid && req_ready;
    assign w_rsp     = (r_state == RESP) && !Reset;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= c_cnt_load;
        end else if ((r_state == WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Request fields are frozen at accept; later input activity is ignored.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_we    <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_oor   <= 1'b0;
        end else if (w_accept) begin
            r_we    <= req_we;
            r_idx   <= w_idx_cur;
            r_wdata <= req_wdata;
            r_be    <= req_be;
            r_oor   <= w_oor_cur;
        end
    end

    // The registered read must land by RESP: in IDLE the live address is
    // used so a zero-wait request reads on its accept edge.
    assign w_ram_addr = (r_state == IDLE) ? w_idx_cur : r_idx;
    assign w_ram_we   = w_rsp && r_we && !r_oor;

    mem_word_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (c_idx_w)
    ) u_ram (
        .clk     (Clk),
        .i_we    (w_ram_we),
        .i_be    (r_be),
        .i_addr  (w_ram_addr),
        .i_wdata (r_wdata[31:0]),
        .o_rdata (w_ram_rdata)
    );

    assign rsp_valid = w_rsp;
    assign rsp_rdata = (w_rsp && !r_we && !r_oor) ? DATA_W'(w_ram_rdata) : '0;

`ifdef MEM_ADDR_CHECK_EN
    assign rsp_err = w_rsp && r_oor;
`else
    assign rsp_err = 1'b0;
`endif

endmodule : data_mem_responder
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Brief    : Directed checks of the responder (WAIT_CYCLES=2 and =0 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

`ifdef MEM_ADDR_CHECK_EN
    localparam bit c_chk = 1'b1;
`else
    localparam bit c_chk = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        va = 1'b0, vb = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        ready_a, ready_b, rsp_valid_a, rsp_valid_b, err_a, err_b;
    logic [31:0] rdata_a, rdata_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut_a (
        .Clk(clk), .Reset(rst), .req_valid(va), .req_ready(ready_a), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid_a), .rsp_rdata(rdata_a), .rsp_err(err_a)
    );

    data_mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(64), .WAIT_CYCLES(0)) u_dut_b (
        .Clk(clk), .Reset(rst), .req_valid(vb), .req_ready(ready_b), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rdata_b), .rsp_err(err_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request on instance A (sel=0) or B (sel=1); lat counts edges from
    // the accept edge to the first sample showing rsp_valid.
    task automatic do_req(input bit sel, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] be,
                          output logic [31:0] rd, output logic er, output int lat);
        int k;
        req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
        if (sel) vb = 1'b1; else va = 1'b1;
        k = 0;
        while (!(sel ? ready_b : ready_a) && k < 20) begin
            @(posedge clk); #1; k++;
        end
        @(posedge clk); #1;
        va = 1'b0; vb = 1'b0;
        req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
        lat = 0;
        while (!(sel ? rsp_valid_b : rsp_valid_a) && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        rd = sel ? rdata_b : rdata_a;
        er = sel ? err_b : err_a;
        @(posedge clk); #1;
        check("rsp_one_cycle", {31'd0, (sel ? rsp_valid_b : rsp_valid_a)}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          acc_t[4];
        int          rsp_t[4];
        int          n_acc, n_rsp, cyc, ready_hi;
        logic        acc_now;
        logic [31:0] b2b_addr[4];
        logic [31:0] b2b_exp[4];

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_ready",  {31'd0, ready_a},     32'd0);
        check("rst_rvalid", {31'd0, rsp_valid_a}, 32'd0);
        check("rst_rdata",  rdata_a,              32'd0);
        check("rst_err",    {31'd0, err_a},       32'd0);
        rst = 1'b0; #1;
        check("ready_after_rst_a", {31'd0, ready_a}, 32'd1);
        check("ready_after_rst_b", {31'd0, ready_b}, 32'd1);

        // Reset mid-WAIT aborts a pending store
        do_req(0, 1'b1, 32'h10, 32'h0BADF00D, 4'hF, rd, er, lat);
        check("prestore_lat", 32'(lat), 32'd2);
        req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h12345678; req_be = 4'hF; va = 1'b1;
        @(posedge clk); #1;
        va = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort_no_rvalid", {31'd0, rsp_valid_a}, 32'd0);
        end
        rst = 1'b0; #1;
        check("abort_ready", {31'd0, ready_a}, 32'd1);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        check("abort_word4", rd, 32'h0BADF00D);

        // Store then load, latency
        do_req(0, 1'b1, 32'h20, 32'hDEADBEEF, 4'hF, rd, er, lat);
        check("st_lat",   32'(lat), 32'd2);
        check("st_rdata", rd,       32'd0);
        check("st_err",   {31'd0, er}, 32'd0);
        do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        check("ld_lat",   32'(lat), 32'd2);
        check("ld_rdata", rd,       32'hDEADBEEF);

        // Byte lanes and empty byte enable
        do_req(0, 1'b1, 32'h40, 32'h11223344, 4'hF, rd, er, lat);
        do_req(0, 1'b1, 32'h40, 32'hAABBCCDD, 4'b0101, rd, er, lat);
        do_req(0, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
        check("lane_merge", rd, 32'h11BB33DD);
        do_req(0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
        check("be0_lat", 32'(lat), 32'd2);
        do_req(0, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
        check("be0_unchanged", rd, 32'h11BB33DD);

        // Back-to-back loads with req_valid held high
        do_req(0, 1'b1, 32'h80, 32'h0000CAFE, 4'hF, rd, er, lat);
        b2b_addr = '{32'h10, 32'h20, 32'h40, 32'h80};
        b2b_exp  = '{32'h0BADF00D, 32'hDEADBEEF, 32'h11BB33DD, 32'h0000CAFE};
        req_we = 1'b0; req_addr = b2b_addr[0]; va = 1'b1;
        n_acc = 0; n_rsp = 0; cyc = 0; ready_hi = 0;
        for (int i = 0; i < 60 && n_rsp < 4; i++) begin
            acc_now = va && ready_a;
            if (va && ready_a) ready_hi++;
            @(posedge clk); #1; cyc++;
            if (acc_now) begin
                acc_t[n_acc] = cyc;
                n_acc++;
                if (n_acc == 4) va = 1'b0;
                else req_addr = b2b_addr[n_acc];
            end
            if (rsp_valid_a) begin
                check("b2b_rdata", rdata_a, b2b_exp[n_rsp]);
                rsp_t[n_rsp] = cyc;
                n_rsp++;
            end
        end
        va = 1'b0;
        @(posedge clk); #1;
        check("b2b_nrsp",     32'(n_rsp),    32'd4);
        check("b2b_ready_hi", 32'(ready_hi), 32'd4);
        if (n_rsp == 4) begin
            for (int i = 0; i < 3; i++)
                check("b2b_spacing", 32'(acc_t[i+1] - acc_t[i]), 32'd4);
            for (int i = 0; i < 4; i++)
                check("b2b_latency", 32'(rsp_t[i] - acc_t[i]), 32'd2);
        end

        // Zero-wait instance and ignored low address bits
        do_req(1, 1'b1, 32'h40, 32'hA5A5A5A5, 4'hF, rd, er, lat);
        check("w0_st_lat", 32'(lat), 32'd0);
        do_req(1, 1'b0, 32'h43, 32'h0, 4'h0, rd, er, lat);
        check("w0_ld_lat",   32'(lat), 32'd0);
        check("w0_ld_alias", rd,       32'hA5A5A5A5);

        // Out-of-range address
        do_req(0, 1'b1, 32'h0, 32'h01020304, 4'hF, rd, er, lat);
        do_req(0, 1'b1, 32'h1000, 32'h55667788, 4'hF, rd, er, lat);
        check("oor_st_err", {31'd0, er}, {31'd0, c_chk});
        check("oor_st_lat", 32'(lat), 32'd2);
        do_req(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
        check("oor_word0", rd, c_chk ? 32'h01020304 : 32'h55667788);
        do_req(0, 1'b0, 32'h1000, 32'h0, 4'h0, rd, er, lat);
        check("oor_ld_rdata", rd, c_chk ? 32'h0 : 32'h55667788);
        check("oor_ld_err", {31'd0, er}, {31'd0, c_chk});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_data_mem_responder
`default_nettype wire
